multicycle_controller: RTL and testbench

//  Multicycle RV32I control FSM: sequences the shared ALU, memory port, register file and

---
 rtl/multicycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM with stallable memory handshake and sticky TRAP
module multicycle_controller #(
   parameter int STALL_LIMIT = 0
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [6:0] OP,
   input  logic [2:0] FUNCT3,
   input  logic       FUNCT7b5,
   input  logic       ZERO,
   input  logic       LT,
   input  logic       LTU,
   input  logic       MEM_READY,
   output logic       MEM_REQ,
   output logic       MEM_WRITE,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [3:0] STATE,
   output logic       TRAP
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam int CW = $clog2(STALL_LIMIT + 2);

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] stall_q, stall_d;
   logic          waiting, timeout, alu_f3_ok, br_f3_ok, br_taken;
   logic [2:0]    alu_op;

   assign waiting   = (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE) && !MEM_READY;
   assign timeout   = waiting && (STALL_LIMIT != 0) && (stall_q == CW'(STALL_LIMIT - 1));
   assign alu_f3_ok = !FUNCT3[0] || FUNCT3 == 3'b111;

   always_comb begin
      case (FUNCT3)
         3'b000:  alu_op = (OP == OP_R && FUNCT7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_op = ALU_SLT;
         3'b100:  alu_op = ALU_XOR;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   end

`ifdef BRANCH_EXT_EN
   logic br_cond;
   always_comb begin
      case (FUNCT3[2:1])
         2'b00:   br_cond = ZERO;
         2'b10:   br_cond = LT;
         2'b11:   br_cond = LTU;
         default: br_cond = 1'b0;
      endcase
   end
   assign br_f3_ok = FUNCT3[2:1] != 2'b01;
   assign br_taken = br_cond ^ FUNCT3[0];
`else
   logic unused_cmp;
   assign unused_cmp = LT ^ LTU;
   assign br_f3_ok   = FUNCT3 == 3'b000;
   assign br_taken   = ZERO;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_FETCH;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = MEM_READY ? S_DECODE : timeout ? S_TRAP : S_FETCH;
         S_DECODE: begin
            case (OP)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = alu_f3_ok ? S_EXECR : S_TRAP;
               OP_I:         state_d = alu_f3_ok ? S_EXECI : S_TRAP;
               OP_BR:        state_d = br_f3_ok ? S_BRANCH : S_TRAP;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = MEM_READY ? S_MEMWB : timeout ? S_TRAP : S_MEMREAD;
         S_MEMWRITE: state_d = MEM_READY ? S_FETCH : timeout ? S_TRAP : S_MEMWRITE;
         S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
         default:    state_d = S_TRAP;
      endcase
      stall_d = (state_d != state_q) ? '0 : (waiting && STALL_LIMIT != 0) ? stall_q + 1'b1 : stall_q;
   end

   always_comb begin
      MEM_REQ    = 1'b0;
      MEM_WRITE  = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = ALU_ADD;
      TRAP       = 1'b0;
      case (state_q)
         S_FETCH: begin
            MEM_REQ   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MEM_READY;
            PCWrite   = MEM_READY;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            MEM_REQ = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            MEM_REQ   = 1'b1;
            MEM_WRITE = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_op;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_op;
         end
         S_ALUWB:  RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            PCWrite    = br_taken;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         S_TRAP:   TRAP = 1'b1;
         default:  TRAP = 1'b1;
      endcase
      if (!RESET_N) begin
         MEM_REQ   = 1'b0;
         MEM_WRITE = 1'b0;
         PCWrite   = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         TRAP      = 1'b0;
      end
   end

   assign ImmSrc = (OP == OP_SW) ? 2'b01 : (OP == OP_BR) ? 2'b10 : (OP == OP_JAL) ? 2'b11 : 2'b00;
   assign STATE  = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench for multicycle_controller (STALL_LIMIT=4)
module tb_multicycle_controller;
   localparam int LIMIT = 4;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] LUI = 7'b0110111;

   typedef struct packed {
      logic [3:0] st;
      logic       req, wr, pcw, irw, rgw, adr;
      logic [1:0] a, b, res;
      logic [2:0] alu;
      logic [1:0] imm;
      logic       trap;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic [6:0] OP = 7'd0;
   logic [2:0] FUNCT3 = 3'd0;
   logic       FUNCT7b5 = 1'b0, ZERO = 1'b0, LT = 1'b0, LTU = 1'b0, MEM_READY = 1'b0;
   logic       MEM_REQ, MEM_WRITE, PCWrite, IRWrite, RegWrite, AdrSrc, TRAP;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] STATE;
   exp_t       got;
   exp_t       q[$];
   string      qn[$];
   int         total = 0, bad = 0;

   multicycle_controller #(.STALL_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7b5(FUNCT7b5),
      .ZERO(ZERO), .LT(LT), .LTU(LTU), .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ),
      .MEM_WRITE(MEM_WRITE), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .STATE(STATE), .TRAP(TRAP)
   );

   always #5 CLK = ~CLK;

   assign got = {STATE, MEM_REQ, MEM_WRITE, PCWrite, IRWrite, RegWrite, AdrSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, TRAP};

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      return op == SW ? 2'b01 : op == BR ? 2'b10 : op == JL ? 2'b11 : 2'b00;
   endfunction

   function automatic bit alu_legal(input logic [2:0] f3);
      return !(f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101);
   endfunction

   function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b100:  return 3'b100;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit br_legal(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
      return f3 != 3'b010 && f3 != 3'b011;
`else
      return f3 == 3'b000;
`endif
   endfunction

   function automatic bit br_take(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t ex(input logic [3:0] st, input logic rdy);
      exp_t e;
      e      = '0;
      e.st   = st;
      e.imm  = imm_of(OP);
      e.trap = st == 4'd11;
      case (st)
         4'd0:  begin e.req = 1; e.b = 2; e.res = 2; e.pcw = rdy; e.irw = rdy; end
         4'd1:  begin e.a = 1; e.b = 1; end
         4'd2:  begin e.a = 2; e.b = 1; end
         4'd3:  begin e.adr = 1; e.req = 1; end
         4'd4:  begin e.res = 1; e.rgw = 1; end
         4'd5:  begin e.adr = 1; e.req = 1; e.wr = 1; end
         4'd6:  begin e.a = 2; e.alu = alu_of(OP, FUNCT3, FUNCT7b5); end
         4'd7:  begin e.a = 2; e.b = 1; e.alu = alu_of(OP, FUNCT3, FUNCT7b5); end
         4'd8:  e.rgw = 1;
         4'd9:  begin e.a = 2; e.alu = 3'b001; e.pcw = br_take(FUNCT3, ZERO, LT, LTU); end
         4'd10: begin e.a = 1; e.b = 2; e.pcw = 1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic exp_t rst_rec();
      exp_t e;
      e     = ex(4'd0, 1'b0);
      e.req = 1'b0;
      return e;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int pick_wait();
      return $urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : $urandom_range(3, 5);
   endfunction

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t  e;
         string n;
         e = q.pop_front();
         n = qn.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h (state got %0d want %0d)", n, $time, got, e, got.st, e.st);
         end
      end
   end

   task automatic step(input exp_t e, input logic rdy, input string n);
      MEM_READY = rdy;
      q.push_back(e);
      qn.push_back(n);
      @(posedge CLK);
      #1;
   endtask

   task automatic mem_phase(input logic [3:0] st, input int w, input string n, output bit ok);
      for (int k = 0; k < w && k < LIMIT; k++) step(ex(st, 1'b0), 1'b0, n);
      ok = w < LIMIT;
      if (ok) step(ex(st, 1'b1), 1'b1, n);
   endtask

   task automatic trap_reset(input string n);
      for (int k = 0; k < 3; k++) step(ex(4'd11, 1'b0), rnd(), n);
      RESET_N = 1'b0;
      step(rst_rec(), 1'b1, "reset_trap");
      step(rst_rec(), 1'b0, "reset_trap");
      RESET_N = 1'b1;
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                            input logic lt, input logic ltu, input int wf, input int wm, input string n);
      bit ok;
      OP = op; FUNCT3 = f3; FUNCT7b5 = f7; ZERO = z; LT = lt; LTU = ltu;
      mem_phase(4'd0, wf, n, ok);
      if (!ok) begin
         trap_reset(n);
         return;
      end
      step(ex(4'd1, 1'b0), rnd(), n);
      if (op == LW || op == SW) begin
         step(ex(4'd2, 1'b0), rnd(), n);
         mem_phase(op == LW ? 4'd3 : 4'd5, wm, n, ok);
         if (!ok) trap_reset(n);
         else if (op == LW) step(ex(4'd4, 1'b0), rnd(), n);
      end else if ((op == RT || op == IT) && alu_legal(f3)) begin
         step(ex(op == RT ? 4'd6 : 4'd7, 1'b0), rnd(), n);
         step(ex(4'd8, 1'b0), rnd(), n);
      end else if (op == BR && br_legal(f3)) begin
         step(ex(4'd9, 1'b0), rnd(), n);
      end else if (op == JL) begin
         step(ex(4'd10, 1'b0), rnd(), n);
         step(ex(4'd8, 1'b0), rnd(), n);
      end else begin
         trap_reset(n);
      end
   endtask

   task automatic run_random();
      int         s;
      logic [6:0] op;
      logic [2:0] f3;
      s  = $urandom_range(0, 7);
      op = s == 0 ? LW : s == 1 ? SW : s == 2 ? RT : s == 3 ? IT : s == 4 ? BR : s == 5 ? JL : s == 6 ? LUI : 7'($urandom);
      f3 = (op == BR && rnd()) ? 3'b000 : 3'($urandom);
      run_instr(op, f3, rnd(), rnd(), rnd(), rnd(), pick_wait(), pick_wait(), "random");
   endtask

   initial begin
      #1 RESET_N = 1'b0;
      @(posedge CLK);
      #1;
      step(rst_rec(), 1'b0, "reset_hold");
      step(rst_rec(), 1'b1, "reset_hold");
      RESET_N = 1'b1;
      run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "add");
      run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "sub");
      run_instr(IT, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "andi");
      run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, "lw_stall2");
      run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, "sw_stall3");
      run_instr(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "beq_taken");
      run_instr(BR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "beq_not");
      run_instr(BR, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "bne");
      run_instr(IT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "slli_trap");
      run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "jal");
      run_instr(LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "lui_trap");
      run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0, "fetch_timeout");
      run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, "memread_timeout");
      run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, 5, "memwrite_timeout");
      OP = RT; FUNCT3 = 3'b000;
      RESET_N = 1'b0;
      #1;
      if (STATE !== 4'd0 || TRAP !== 1'b0) begin
         bad++;
         $display("FAIL async_reset t=%0t state=%0d trap=%b want state=0 trap=0", $time, STATE, TRAP);
      end
      step(rst_rec(), 1'b1, "reset_fetch");
      RESET_N = 1'b1;
      OP = LW; FUNCT3 = 3'b010;
      step(ex(4'd0, 1'b1), 1'b1, "reset_mid");
      step(ex(4'd1, 1'b0), 1'b0, "reset_mid");
      step(ex(4'd2, 1'b0), 1'b0, "reset_mid");
      step(ex(4'd3, 1'b0), 1'b0, "reset_mid");
      RESET_N = 1'b0;
      step(rst_rec(), 1'b1, "reset_mid");
      RESET_N = 1'b1;
      for (int i = 0; i < 400; i++) run_random();
      repeat (2) @(negedge CLK);
      if (total == 0) begin
         bad++;
         $display("FAIL no_checks total=%0d want>0", total);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog t=%0t pending=%0d want=0", $time, q.size());
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
